// File: rtl/mdio_phy_responder.sv
// MDIO Clause-22 PHY-side responder.
// MDC/MDIO/link are oversampled in the i_sysclk domain. A small register file is
// held here, and MDIO is driven during read turnaround and data. The pin
// tri-state is built one level up from o_mdio/o_mdio_oe.
module mdio_phy_responder #(
  parameter logic [4:0]  P_PHY_ADDR    = 5'b00001,
  parameter int          P_PRE_LEN     = 32,
  parameter logic [15:0] P_REG0_INIT   = 16'h0140,
  parameter logic [15:0] P_STATUS_BASE = 16'h7949,
  parameter logic [15:0] P_PHY_ID1     = 16'h0141,
  parameter logic [15:0] P_PHY_ID2     = 16'h0DD1
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        o_mdio_oe,
  input  logic        i_link,
  output logic [15:0] o_ctrl_reg,
  output logic        o_wr_pulse,
  output logic [4:0]  o_wr_addr,
  output logic        o_frame_err
);

  localparam int PRE_W = $clog2(P_PRE_LEN + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(P_PRE_LEN);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ST1   = 3'd1,
    ST_OP    = 3'd2,
    ST_PHYAD = 3'd3,
    ST_REGAD = 3'd4,
    ST_TA    = 3'd5,
    ST_DATA  = 3'd6
  } state_t;

  // Synchroniser and edge-detect registers
  logic mdc_meta_r, mdc_sync_r, mdc_prev_r;
  logic mdio_meta_r, mdio_sync_r;
  logic link_meta_r, link_sync_r;
  logic mdc_rise_s;

  // Frame decoder state
  state_t           state_r, state_nxt;
  logic [3:0]       bit_cnt_r, bit_cnt_nxt;
  logic [PRE_W-1:0] pre_cnt_r, pre_cnt_nxt;
  logic             is_rd_r, is_rd_nxt;
  logic [4:0]       phyad_r, phyad_nxt;
  logic [4:0]       regad_r, regad_nxt;
  logic             match_r, match_nxt;
  logic [15:0]      shift_r, shift_nxt;
  logic             mdio_r, mdio_nxt;
  logic             oe_r, oe_nxt;
  logic             ferr_r, ferr_nxt;
  logic             commit_s;
  logic [15:0]      commit_data_s;

  // Register file
  logic [15:0]      reg0_r;
  logic [3:0][15:0] scratch_r;
  logic             wr_pulse_r;
  logic [4:0]       wr_addr_r;

  // Read value for a register address; reg0 bit15 (self-clearing reset) always reads 0
  function automatic logic [15:0] read_mux(input logic [4:0] addr, input logic [15:0] reg0,
                                           input logic link, input logic [3:0][15:0] scr);
    case (addr)
      5'd0:                    read_mux = {1'b0, reg0[14:0]};
      5'd1:                    read_mux = {P_STATUS_BASE[15:3], link, P_STATUS_BASE[1:0]};
      5'd2:                    read_mux = P_PHY_ID1;
      5'd3:                    read_mux = P_PHY_ID2;
      5'd4, 5'd5, 5'd6, 5'd7:  read_mux = scr[addr[1:0]];
      default:                 read_mux = 16'h0000;
    endcase
  endfunction

  // Only reg0 and the scratch registers 4-7 accept writes
  function automatic logic is_writable(input logic [4:0] addr);
    is_writable = (addr == 5'd0) || (addr[4:2] == 3'b001);
  endfunction

  assign mdc_rise_s = mdc_sync_r & ~mdc_prev_r;

  // Two-flop synchronisers for the asynchronous pins plus MDC edge history
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      mdc_meta_r  <= 1'b0;
      mdc_sync_r  <= 1'b0;
      mdc_prev_r  <= 1'b0;
      mdio_meta_r <= 1'b0;
      mdio_sync_r <= 1'b0;
      link_meta_r <= 1'b0;
      link_sync_r <= 1'b0;
    end else begin
      mdc_meta_r  <= i_mdc;
      mdc_sync_r  <= mdc_meta_r;
      mdc_prev_r  <= mdc_sync_r;
      mdio_meta_r <= i_mdio;
      mdio_sync_r <= mdio_meta_r;
      link_meta_r <= i_link;
      link_sync_r <= link_meta_r;
    end
  end

  // Decoder state register and registered MDIO drive / error pulse
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 4'd0;
      pre_cnt_r <= '0;
      is_rd_r   <= 1'b0;
      phyad_r   <= 5'd0;
      regad_r   <= 5'd0;
      match_r   <= 1'b0;
      shift_r   <= 16'h0000;
      mdio_r    <= 1'b0;
      oe_r      <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      bit_cnt_r <= bit_cnt_nxt;
      pre_cnt_r <= pre_cnt_nxt;
      is_rd_r   <= is_rd_nxt;
      phyad_r   <= phyad_nxt;
      regad_r   <= regad_nxt;
      match_r   <= match_nxt;
      shift_r   <= shift_nxt;
      mdio_r    <= mdio_nxt;
      oe_r      <= oe_nxt;
      ferr_r    <= ferr_nxt;
    end
  end

  // Next-state / output decode; everything advances only on a synchronised MDC rise
  always_comb begin
    state_nxt     = state_r;
    bit_cnt_nxt   = bit_cnt_r;
    pre_cnt_nxt   = pre_cnt_r;
    is_rd_nxt     = is_rd_r;
    phyad_nxt     = phyad_r;
    regad_nxt     = regad_r;
    match_nxt     = match_r;
    shift_nxt     = shift_r;
    mdio_nxt      = mdio_r;
    oe_nxt        = oe_r;
    ferr_nxt      = 1'b0;
    commit_s      = 1'b0;
    commit_data_s = {shift_r[14:0], mdio_sync_r};
    if (mdc_rise_s) begin
      case (state_r)
        ST_IDLE: begin
          if (mdio_sync_r) begin
            if (pre_cnt_r < PRE_MAX) begin
              pre_cnt_nxt = pre_cnt_r + PRE_ONE;
            end else begin
              pre_cnt_nxt = PRE_MAX;
            end
          end else if (pre_cnt_r >= PRE_MAX) begin
            state_nxt   = ST_ST1;
            pre_cnt_nxt = '0;
          end else begin
            pre_cnt_nxt = '0;
          end
        end
        ST_ST1: begin
          if (mdio_sync_r) begin
            state_nxt   = ST_OP;
            bit_cnt_nxt = 4'd0;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_OP: begin
          // First OP bit is 1 for a read (10) and 0 for a write (01); equal bits are illegal
          if (bit_cnt_r == 4'd0) begin
            is_rd_nxt   = mdio_sync_r;
            bit_cnt_nxt = 4'd1;
          end else if (is_rd_r != mdio_sync_r) begin
            state_nxt   = ST_PHYAD;
            bit_cnt_nxt = 4'd0;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_PHYAD: begin
          phyad_nxt = {phyad_r[3:0], mdio_sync_r};
          if (bit_cnt_r == 4'd4) begin
            state_nxt   = ST_REGAD;
            bit_cnt_nxt = 4'd0;
          end else begin
            bit_cnt_nxt = bit_cnt_r + 4'd1;
          end
        end
        ST_REGAD: begin
          regad_nxt = {regad_r[3:0], mdio_sync_r};
          if (bit_cnt_r == 4'd4) begin
            match_nxt   = (phyad_r == P_PHY_ADDR);
            shift_nxt   = read_mux({regad_r[3:0], mdio_sync_r}, reg0_r, link_sync_r, scratch_r);
            state_nxt   = ST_TA;
            bit_cnt_nxt = 4'd0;
          end else begin
            bit_cnt_nxt = bit_cnt_r + 4'd1;
          end
        end
        ST_TA: begin
          if (is_rd_r) begin
            if (bit_cnt_r == 4'd0) begin
              // Station has released the line; drive the TA zero only if addressed
              oe_nxt      = match_r;
              mdio_nxt    = 1'b0;
              bit_cnt_nxt = 4'd1;
            end else begin
              mdio_nxt    = match_r & shift_r[15];
              shift_nxt   = {shift_r[14:0], 1'b0};
              state_nxt   = ST_DATA;
              bit_cnt_nxt = 4'd0;
            end
          end else if (mdio_sync_r == (bit_cnt_r == 4'd0)) begin
            if (bit_cnt_r == 4'd0) begin
              bit_cnt_nxt = 4'd1;
            end else begin
              state_nxt   = ST_DATA;
              bit_cnt_nxt = 4'd0;
            end
          end else begin
            // Bad write turnaround; frames for other PHYs are dropped silently
            ferr_nxt    = match_r;
            state_nxt   = ST_IDLE;
            pre_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          if (is_rd_r) begin
            if (bit_cnt_r == 4'd15) begin
              oe_nxt   = 1'b0;
              mdio_nxt = 1'b0;
            end else begin
              mdio_nxt  = match_r & shift_r[15];
              shift_nxt = {shift_r[14:0], 1'b0};
            end
          end else begin
            shift_nxt = {shift_r[14:0], mdio_sync_r};
            if (bit_cnt_r == 4'd15) begin
              commit_s = match_r & is_writable(regad_r);
            end else begin
              commit_s = 1'b0;
            end
          end
          if (bit_cnt_r == 4'd15) begin
            state_nxt   = ST_IDLE;
            pre_cnt_nxt = '0;
            bit_cnt_nxt = 4'd0;
          end else begin
            bit_cnt_nxt = bit_cnt_r + 4'd1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          oe_nxt    = 1'b0;
          mdio_nxt  = 1'b0;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  // Register file update on a committed write; reg0 bit15 triggers a soft reset
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      reg0_r     <= P_REG0_INIT;
      scratch_r  <= '0;
      wr_pulse_r <= 1'b0;
      wr_addr_r  <= 5'd0;
    end else begin
      wr_pulse_r <= commit_s;
      if (commit_s) begin
        wr_addr_r <= regad_r;
        if (regad_r == 5'd0) begin
          if (commit_data_s[15]) begin
            reg0_r    <= P_REG0_INIT;
            scratch_r <= '0;
          end else begin
            reg0_r <= {1'b0, commit_data_s[14:0]};
          end
        end else begin
          scratch_r[regad_r[1:0]] <= commit_data_s;
        end
      end
    end
  end

  assign o_mdio      = mdio_r;
  assign o_mdio_oe   = oe_r;
  assign o_frame_err = ferr_r;
  assign o_ctrl_reg  = reg0_r;
  assign o_wr_pulse  = wr_pulse_r;
  assign o_wr_addr   = wr_addr_r;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Scoreboard bench for mdio_phy_responder: the station task pushes expected
// read bursts, writes and frame errors; monitors pop and compare.
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        link;
  logic        st_oe;
  logic        st_val;
  logic        mdio_in;
  logic        o_mdio, o_mdio_oe, o_wr_pulse, o_frame_err;
  logic [15:0] o_ctrl_reg;
  logic [4:0]  o_wr_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [16:0] bits;
    int          n;
  } rd_exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] ctrl;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      ferr_pending = 0;

  logic [16:0] burst = 17'h0;
  int          burst_n = 0;
  logic        oe_prev = 1'b0;

  always #5 clk = ~clk;

  // Open-drain style bus with pull-up: DUT wins when enabled, else station, else 1
  assign mdio_in = o_mdio_oe ? o_mdio : (st_oe ? st_val : 1'b1);

  mdio_phy_responder dut (
    .i_sysclk    (clk),
    .i_sysrst    (rst),
    .i_mdc       (mdc),
    .i_mdio      (mdio_in),
    .o_mdio      (o_mdio),
    .o_mdio_oe   (o_mdio_oe),
    .i_link      (link),
    .o_ctrl_reg  (o_ctrl_reg),
    .o_wr_pulse  (o_wr_pulse),
    .o_wr_addr   (o_wr_addr),
    .o_frame_err (o_frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One MDC period of 16 sysclk; data changes with MDC low
  task automatic send_bit(input logic b, input logic drv);
    @(negedge clk);
    mdc    = 1'b0;
    st_oe  = drv;
    st_val = b;
    repeat (8) @(negedge clk);
    mdc = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] data,
                       input int nbits);
    logic [31:0] v;
    v = {2'b01, op, phy, ra, ta, data};
    for (int i = 0; i < pre; i++) send_bit(1'b1, 1'b1);
    for (int i = 31; i > 31 - nbits; i--) send_bit(v[i], !(op == 2'b10 && i < 18));
    st_oe = 1'b0;
  endtask

  task automatic rd(input logic [4:0] ra, input logic [15:0] exp);
    rd_exp_t e;
    e.bits = {1'b0, exp};
    e.n    = 17;
    rd_q.push_back(e);
    frame(32, 2'b10, 5'd1, ra, 2'b00, 16'h0000, 32);
  endtask

  task automatic wr(input logic [4:0] ra, input logic [15:0] d, input logic pulse,
                    input logic [15:0] ctrl_after);
    wr_exp_t w;
    if (pulse) begin
      w.addr = ra;
      w.ctrl = ctrl_after;
      wr_q.push_back(w);
    end
    frame(32, 2'b01, 5'd1, ra, 2'b10, d, 32);
  endtask

  // Collect bits the station would sample while the DUT drives MDIO
  always @(posedge mdc) begin
    if (o_mdio_oe) begin
      burst = {burst[15:0], mdio_in};
      burst_n++;
    end
  end

  // Close a read burst when the DUT releases MDIO and score it
  always @(negedge clk) begin
    rd_exp_t e;
    if (oe_prev && !o_mdio_oe) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected_burst", burst_n, 0);
      end else begin
        e = rd_q.pop_front();
        check("rd_len", burst_n, e.n);
        check("rd_data", {15'h0, burst}, {15'h0, e.bits >> (17 - e.n)});
      end
      burst   = 17'h0;
      burst_n = 0;
    end
    oe_prev = o_mdio_oe;
  end

  // Score write-commit and frame-error pulses
  always @(negedge clk) begin
    wr_exp_t w;
    if (o_wr_pulse || o_frame_err) begin
      check("wr_ferr_exclusive", {31'h0, o_wr_pulse & o_frame_err}, 32'h0);
    end
    if (o_wr_pulse) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected_pulse", {27'h0, o_wr_addr}, 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        check("wr_addr", {27'h0, o_wr_addr}, {27'h0, w.addr});
        check("wr_ctrl", {16'h0, o_ctrl_reg}, {16'h0, w.ctrl});
      end
    end
    if (o_frame_err) begin
      check("ferr_expected", ferr_pending, (ferr_pending > 0) ? ferr_pending : 1);
      if (ferr_pending > 0) ferr_pending--;
    end
  end

  initial begin
    rd_exp_t e;
    rst    = 1'b1;
    mdc    = 1'b0;
    link   = 1'b0;
    st_oe  = 1'b0;
    st_val = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_oe",      {31'h0, o_mdio_oe},   32'h0);
    check("rst_mdio",    {31'h0, o_mdio},      32'h0);
    check("rst_wr_pulse",{31'h0, o_wr_pulse},  32'h0);
    check("rst_wr_addr", {27'h0, o_wr_addr},   32'h0);
    check("rst_ferr",    {31'h0, o_frame_err}, 32'h0);
    check("rst_ctrl",    {16'h0, o_ctrl_reg},  32'h0000_0140);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    rd(5'd0, 16'h0140);
    link = 1'b1;
    rd(5'd1, 16'h794D);
    link = 1'b0;
    rd(5'd1, 16'h7949);

    wr(5'd0, 16'h2100, 1'b1, 16'h2100);
    check("ctrl_after_wr", {16'h0, o_ctrl_reg}, 32'h0000_2100);
    rd(5'd0, 16'h2100);
    wr(5'd4, 16'hBEEF, 1'b1, 16'h2100);
    rd(5'd4, 16'hBEEF);
    wr(5'd7, 16'h0F0F, 1'b1, 16'h2100);
    wr(5'd0, 16'h8000, 1'b1, 16'h0140);
    check("ctrl_after_softrst", {16'h0, o_ctrl_reg}, 32'h0000_0140);
    rd(5'd4, 16'h0000);
    rd(5'd7, 16'h0000);
    rd(5'd0, 16'h0140);

    // Other PHY address: silently consumed, then a normal frame
    frame(32, 2'b10, 5'b00010, 5'd0, 2'b00, 16'h0000, 32);
    rd(5'd2, 16'h0141);
    rd(5'd3, 16'h0DD1);

    // Writes to read-only / unmapped registers
    wr(5'd9, 16'hFFFF, 1'b0, 16'h0140);
    wr(5'd1, 16'h0000, 1'b0, 16'h0140);
    rd(5'd9, 16'h0000);
    rd(5'd1, 16'h7949);

    // Short preamble is ignored
    frame(31, 2'b10, 5'd1, 5'd0, 2'b00, 16'h0000, 32);
    rd(5'd3, 16'h0DD1);

    // Illegal opcode
    ferr_pending++;
    frame(32, 2'b11, 5'd1, 5'd0, 2'b10, 16'h1234, 32);

    // Write with bad turnaround leaves the target unchanged
    wr(5'd5, 16'h5A5A, 1'b1, 16'h0140);
    ferr_pending++;
    frame(32, 2'b01, 5'd1, 5'd5, 2'b00, 16'hFFFF, 32);
    rd(5'd5, 16'h5A5A);

    // Reset in the middle of read data bit D8
    wr(5'd0, 16'h1200, 1'b1, 16'h1200);
    e.bits = {1'b0, 16'h1200};
    e.n    = 8;
    rd_q.push_back(e);
    frame(32, 2'b10, 5'd1, 5'd0, 2'b00, 16'h0000, 23);
    check("oe_before_abort", {31'h0, o_mdio_oe}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_oe", {31'h0, o_mdio_oe}, 32'h0);
    @(negedge clk);
    check("abort_ctrl", {16'h0, o_ctrl_reg}, 32'h0000_0140);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rd(5'd0, 16'h0140);

    repeat (50) @(negedge clk);
    check("rd_q_empty",  rd_q.size(),  32'h0);
    check("wr_q_empty",  wr_q.size(),  32'h0);
    check("ferr_all_seen", ferr_pending, 32'h0);
    check("burst_idle",  burst_n,      32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- MDIO slave (PHY-side management responder) for the Clause-22 frames issued by our station-management/PHY-init logic.
- Used in simulation and loopback builds as the PHY model behind the MDC/MDIO pins.
- Decodes frames oversampled in the i_sysclk domain, holds a small register file, and drives MDIO during read turnaround and data.
- Top level builds the MDIO tri-state from o_mdio/o_mdio_oe.

Parameters:
- P_PHY_ADDR, 5'b00001, PHY address this responder answers to.
- P_PRE_LEN, 32, minimum consecutive preamble ones before a start is accepted.
- P_REG0_INIT, 16'h0140, reset/soft-reset value of reg 0 (bit6=1, bit13=0 → 1000M).
- P_STATUS_BASE, 16'h7949, fixed bits of reg 1; bit2 is replaced by the live link.
- P_PHY_ID1, 16'h0141, reg 2 read value.
- P_PHY_ID2, 16'h0DD1, reg 3 read value.

Ports:
- i_sysclk  in  1  system clock; must be ≥8× MDC frequency.
- i_sysrst  in  1  reset.
- i_mdc  in  1  MDC from the station, asynchronous.
- i_mdio  in  1  MDIO pin input, asynchronous.
- o_mdio  out  1  MDIO drive value.
- o_mdio_oe  out  1  MDIO output enable; 1 = drive.
- i_link  in  1  link status, asynchronous; appears in reg1[2].
- o_ctrl_reg  out  16  current reg 0 contents.
- o_wr_pulse  out  1  one-cycle pulse on each committed register write.
- o_wr_addr  out  5  register address of the last committed write.
- o_frame_err  out  1  one-cycle pulse on a malformed frame.

Interface decision: one clock, i_sysclk; reset i_sysrst is synchronous and active-high.

Behaviour:
- **Reset values:**
  - o_mdio=0, o_mdio_oe=0, o_wr_pulse=0, o_wr_addr=0, o_frame_err=0.
  - reg0=P_REG0_INIT; regs 4-7 = 0.
  - FSM in ST_IDLE with preamble count 0.
  - Reset asserted mid-frame aborts the frame and releases MDIO on the next cycle.
- **Input synchronisation:**
  - i_mdc, i_mdio and i_link each pass through a 2-FF synchroniser.
  - mdc_rise is a 1-cycle pulse when synchronised MDC is 1 and its previous value was 0.
  - All bit sampling happens on mdc_rise only.
- **Outputs:** o_mdio and o_mdio_oe are registered and update the cycle after mdc_rise.
- **Register map:**
  - reg0 is RW. Writing bit15=1 reloads reg0 to P_REG0_INIT and clears regs 4-7; bit15 always reads 0.
  - reg1 reads P_STATUS_BASE with bit2 = synchronised i_link; writes are ignored.
  - reg2/reg3 read P_PHY_ID1/P_PHY_ID2 and are read-only.
  - regs 4-7 are RW scratch.
  - Addresses 8-31 read 16'h0000; writes are ignored with no o_wr_pulse.
- **FSM** (each step consumes one mdc_rise):
  - **ST_IDLE:**
    - Sampled 1: ones counter increments, saturating at P_PRE_LEN.
    - Sampled 0 with counter ≥ P_PRE_LEN: go to ST_ST1.
    - Sampled 0 otherwise: counter clears.
  - **ST_ST1:** expects 1 → ST_OP. Otherwise pulse o_frame_err and return to ST_IDLE.
  - **ST_OP:** 2 bits. 01 = write, 10 = read; 00/11 pulse o_frame_err → ST_IDLE.
  - **ST_PHYAD:** 5 bits, MSB first.
  - **ST_REGAD:** 5 bits, MSB first. At the last bit, compare PHYAD with P_PHY_ADDR.
    - Mismatch: frame is consumed silently, oe never asserted, then ST_IDLE.
    - Read: the 16-bit read value is snapshotted here.
  - **ST_TA:** 2 bits.
    - Read: oe stays 0 through the rise sampling TA bit1. After that rise, drive 0 with oe=1.
    - Write: expects 1 then 0. Any mismatch pulses o_frame_err, suppresses the commit, and returns to ST_IDLE.
  - **ST_DATA:** 16 bits.
    - Read: drive D15 after the TA bit2 rise, then each next bit after each rise. After the rise ending D0, oe=0.
    - Write: shift in MSB first. On the rise sampling D0, commit the register, pulse o_wr_pulse, and load o_wr_addr.
  - ST_DATA → ST_IDLE with the ones counter cleared. Back-to-back frames therefore need a fresh preamble.
- o_frame_err and o_wr_pulse never assert in the same cycle.

Test Plan:
- Read reg0 after reset (32×1 preamble, 01 10 00001 00000): TA bit2 driven 0, data = 16'h0140 MSB first; oe high for exactly 17 MDC bits, then released.
- i_link=1, read reg1 → 16'h794D; i_link=0 → 16'h7949.
- Write reg0=16'h2100 then read back: o_wr_pulse once with o_wr_addr=0, o_ctrl_reg=16'h2100, read returns 16'h2100. Then write 16'h8000: o_ctrl_reg returns to 16'h0140 and regs 4-7 read 0.
- Frame addressed to PHY 5'b00010: no oe assertion, no wr pulse, no frame_err; a following valid frame is answered normally.
- Preamble of only 31 ones then 01: ignored. OP=11: o_frame_err pulse. Write with TA=00: o_frame_err pulse, target register unchanged.
- Assert i_sysrst during read data bit D8: oe=0 the next cycle and reg0 back to 16'h0140; the next complete read succeeds.
